// File: rtl/gowin_pll_ctrl.sv
// rtl/gowin_pll_ctrl.sv - Gowin PLL power-up, loop-filter retry and relock sequencer
// Define PLL_CTRL_STATS_EN to enable the saturating lock-loss counter.
module gowin_pll_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_icpsel,
  output logic [2:0] pll_lpfres,
  output logic [1:0] pll_lpfcap,
  output logic       pll_enclk0,
  output logic       pll_enclk2,
  output logic       clk_ready,
  output logic [1:0] cfg_idx,
  output logic       fail,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [2:0] ST_HOLD   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  localparam int HW = (RST_CYCLES > 1)    ? $clog2(RST_CYCLES)    : 1;
  localparam int TW = (LOCK_TIMEOUT > 1)  ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 1)   ? $clog2(MAX_RETRIES)   : 1;

  logic [2:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stab_cnt;
  logic [RW-1:0] retry;
  logic          lock_m;
  logic          lock_s;
  logic [1:0]    cfg_next;
  logic          hold_done;
  logic          stable_done;
  logic          timed_out;
  logic          last_try;

  function automatic logic [10:0] filt_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    filt_entry = {6'd12, 3'd4, 2'b00};
      2'd1:    filt_entry = {6'd8,  3'd5, 2'b00};
      2'd2:    filt_entry = {6'd16, 3'd3, 2'b01};
      default: filt_entry = {6'd20, 3'd2, 2'b01};
    endcase
  endfunction

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  assign cfg_next    = cfg_idx + 2'd1;
  assign hold_done   = (hold_cnt == HW'(RST_CYCLES - 1));
  assign stable_done = lock_s && (stab_cnt == SW'(STABLE_CYCLES - 1));
  assign timed_out   = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));
  assign last_try    = (retry == RW'(MAX_RETRIES - 1));

  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= ST_HOLD;
      pll_reset  <= 1'b1;
      pll_enclk0 <= 1'b0;
      pll_enclk2 <= 1'b0;
      clk_ready  <= 1'b0;
      fail       <= 1'b0;
      cfg_idx    <= 2'd0;
      retry      <= '0;
      hold_cnt   <= '0;
      tmo_cnt    <= '0;
      stab_cnt   <= '0;
      {pll_icpsel, pll_lpfres, pll_lpfcap} <= filt_entry(2'd0);
    end else if (restart) begin
      // restart wins over any lock loss or timeout in the same cycle
      state      <= ST_HOLD;
      pll_reset  <= 1'b1;
      pll_enclk0 <= 1'b0;
      pll_enclk2 <= 1'b0;
      clk_ready  <= 1'b0;
      fail       <= 1'b0;
      cfg_idx    <= 2'd0;
      retry      <= '0;
      hold_cnt   <= '0;
      {pll_icpsel, pll_lpfres, pll_lpfcap} <= filt_entry(2'd0);
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_done) begin
            state     <= ST_WAIT;
            pll_reset <= 1'b0;
            tmo_cnt   <= '0;
            hold_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_WAIT, ST_STABLE: begin
          if (state == ST_STABLE && stable_done) begin
            state      <= ST_RUN;
            pll_enclk0 <= 1'b1;
            pll_enclk2 <= 1'b1;
            clk_ready  <= 1'b1;
          end else if (timed_out) begin
            pll_reset <= 1'b1;
            if (last_try) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              // filter settings only move together with entry into HOLD
              state    <= ST_HOLD;
              retry    <= retry + 1'b1;
              cfg_idx  <= cfg_next;
              hold_cnt <= '0;
              {pll_icpsel, pll_lpfres, pll_lpfcap} <= filt_entry(cfg_next);
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ST_WAIT) begin
              if (lock_s) begin
                state    <= ST_STABLE;
                stab_cnt <= '0;
              end
            end else if (!lock_s) begin
              state <= ST_WAIT;
            end else begin
              stab_cnt <= stab_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          retry <= '0;
          if (!lock_s) begin
            state      <= ST_HOLD;
            pll_reset  <= 1'b1;
            pll_enclk0 <= 1'b0;
            pll_enclk2 <= 1'b0;
            clk_ready  <= 1'b0;
            hold_cnt   <= '0;
            {pll_icpsel, pll_lpfres, pll_lpfcap} <= filt_entry(cfg_idx);
          end
        end
        ST_FAIL: begin
          pll_reset  <= 1'b1;
          pll_enclk0 <= 1'b0;
          pll_enclk2 <= 1'b0;
          clk_ready  <= 1'b0;
          fail       <= 1'b1;
        end
        default: begin
          state     <= ST_HOLD;
          pll_reset <= 1'b1;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef PLL_CTRL_STATS_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge clkin) begin
    if (reset) begin
      loss_cnt <= 8'd0;
    end else if (!restart && state == ST_RUN && !lock_s && loss_cnt != 8'hFF) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
